// File: rtl/emif_amm_master.sv
// -----------------------------------------------------------------------------
// emif_amm_master
//
// Purpose:
//   Pattern-driven Avalon-MM burst master for EMIF traffic generation. It
//   accepts one command at a time. A write command streams a burst of
//   pattern beats. A read command issues a burst read and checks every
//   returned beat against the same pattern. Mismatches are counted in a
//   saturating counter.
//
//   The pattern for beat b is DATA_W/32 copies of (seed + b) mod 2^32.
//
// Ports:
//   emif_usr_clk, emif_usr_reset  single clock, synchronous active-high reset
//   local_cal_success             EMIF calibration done; gates cmd_ready
//   cmd_valid / cmd_ready         command handshake
//   cmd_write, cmd_addr,          command fields (1=write, word address,
//   cmd_len, cmd_seed             beats, pattern seed)
//   amm_*                         Avalon-MM master (amm_ready = waitrequest_n)
//   busy                          high whenever a command is in flight
//   done                          one-cycle pulse at command completion
//   err_count                     saturating read mismatch count
//   timeout                       sticky read watchdog flag
//
// Configuration:
//   EMIF_AMM_MASTER_TIMEOUT_EN    when defined, adds a read watchdog. After
//                                 1024 RD_DATA cycles with no readdatavalid,
//                                 it sets timeout, pulses done and returns
//                                 to IDLE. When undefined, timeout is tied
//                                 to 0 and RD_DATA waits forever.
// -----------------------------------------------------------------------------
module emif_amm_master #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 576,
  parameter int BURST_W = 7
) (
  input  logic                  emif_usr_clk,
  input  logic                  emif_usr_reset,
  input  logic                  local_cal_success,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [BURST_W-1:0]    cmd_len,
  input  logic [31:0]           cmd_seed,
  input  logic                  amm_ready,
  output logic                  amm_read,
  output logic                  amm_write,
  output logic [ADDR_W-1:0]     amm_address,
  output logic [BURST_W-1:0]    amm_burstcount,
  output logic [DATA_W-1:0]     amm_writedata,
  output logic [DATA_W/8-1:0]   amm_byteenable,
  input  logic [DATA_W-1:0]     amm_readdata,
  input  logic                  amm_readdatavalid,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic                  timeout
);

  localparam int WORDS = DATA_W / 32;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_REQ, RD_DATA} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   len_q, len_d;
  logic [31:0]          seed_q, seed_d;
  logic [BURST_W-1:0]   beat_q, beat_d;
  logic [15:0]          err_count_q, err_count_d;
  logic                 done_q, done_d;

`ifdef EMIF_AMM_MASTER_TIMEOUT_EN
  logic [9:0]           wd_q, wd_d;
  logic                 timeout_q, timeout_d;
`endif

  logic                 cmd_accept;
  logic                 last_beat;
  logic [31:0]          cur_word;
  logic [DATA_W-1:0]    pattern;

  // Expected beat contents. The same pattern drives write data and serves
  // as the read-check reference.
  always_comb begin
    cur_word = seed_q + 32'(beat_q);
    pattern  = {WORDS{cur_word}};
  end

  // Commands are only taken in IDLE once calibration is complete. Reset is
  // folded in so that cmd_ready reads 0 while reset is held.
  assign cmd_ready  = (state_q == IDLE) && local_cal_success && !emif_usr_reset;
  assign cmd_accept = cmd_valid && cmd_ready;

  // beat_q never exceeds len_q-1, so this compare cannot wrap within a burst.
  assign last_beat  = (beat_q == len_q - BURST_W'(1));

  // State register: every flop is reloaded from its _d value. Reset
  // aborts any in-flight burst.
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      beat_q      <= '0;
      err_count_q <= '0;
      done_q      <= 1'b0;
`ifdef EMIF_AMM_MASTER_TIMEOUT_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      beat_q      <= beat_d;
      err_count_q <= err_count_d;
      done_q      <= done_d;
`ifdef EMIF_AMM_MASTER_TIMEOUT_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next-state and datapath logic.
  // - A zero-length command completes immediately without leaving IDLE.
  // - Read beats are looked at only in RD_DATA. Any readdatavalid seen in
  //   another state is ignored.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    seed_d      = seed_q;
    beat_d      = beat_q;
    err_count_d = err_count_q;
    done_d      = 1'b0;
`ifdef EMIF_AMM_MASTER_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          seed_d = cmd_seed;
          beat_d = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (cmd_write) begin
            state_d = WR_BURST;
          end else begin
            state_d = RD_REQ;
          end
        end
      end

      WR_BURST: begin
        if (amm_ready) begin
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + BURST_W'(1);
          end
        end
      end

      RD_REQ: begin
        if (amm_ready) begin
          state_d = RD_DATA;
          beat_d  = '0;
`ifdef EMIF_AMM_MASTER_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end

      RD_DATA: begin
        if (amm_readdatavalid) begin
          if ((amm_readdata != pattern) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + BURST_W'(1);
          end
`ifdef EMIF_AMM_MASTER_TIMEOUT_EN
          wd_d = '0;
        end else if (wd_q == 10'd1023) begin
          // The 1024th silent cycle gives up on the burst.
          timeout_d = 1'b1;
          state_d   = IDLE;
          done_d    = 1'b1;
        end else begin
          wd_d = wd_q + 10'd1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output logic: bus strobes are decoded from the state alone, so read
  // and write can never be asserted together. Address and burstcount are
  // held constant from the registered command for the whole request.
  always_comb begin
    amm_read       = 1'b0;
    amm_write      = 1'b0;
    amm_address    = '0;
    amm_burstcount = '0;
    amm_writedata  = '0;
    amm_byteenable = '1;
    busy           = (state_q != IDLE);
    done           = done_q;
    err_count      = err_count_q;

    case (state_q)
      WR_BURST: begin
        amm_write      = 1'b1;
        amm_address    = addr_q;
        amm_burstcount = len_q;
        amm_writedata  = pattern;
      end
      RD_REQ: begin
        amm_read       = 1'b1;
        amm_address    = addr_q;
        amm_burstcount = len_q;
      end
      default: ;
    endcase
  end

`ifdef EMIF_AMM_MASTER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_emif_amm_master.sv
// -----------------------------------------------------------------------------
// tb_emif_amm_master
//
// Directed testbench for emif_amm_master. It uses the default parameters.
// Each scenario task drives its own stimulus and compares the DUT outputs
// against hand-computed values. The bench sets inputs and samples outputs
// 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_emif_amm_master;

  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 576;
  localparam int BURST_W = 7;

  logic                clk;
  logic                rst;
  logic                cal;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [BURST_W-1:0]  cmd_len;
  logic [31:0]         cmd_seed;
  logic                amm_ready;
  logic                amm_read;
  logic                amm_write;
  logic [ADDR_W-1:0]   amm_address;
  logic [BURST_W-1:0]  amm_burstcount;
  logic [DATA_W-1:0]   amm_writedata;
  logic [DATA_W/8-1:0] amm_byteenable;
  logic [DATA_W-1:0]   amm_readdata;
  logic                amm_readdatavalid;
  logic                busy;
  logic                done;
  logic [15:0]         err_count;
  logic                timeout;

  int checks = 0;
  int errors = 0;

  emif_amm_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BURST_W(BURST_W)
  ) dut (
    .emif_usr_clk     (clk),
    .emif_usr_reset   (rst),
    .local_cal_success(cal),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .cmd_seed         (cmd_seed),
    .amm_ready        (amm_ready),
    .amm_read         (amm_read),
    .amm_write        (amm_write),
    .amm_address      (amm_address),
    .amm_burstcount   (amm_burstcount),
    .amm_writedata    (amm_writedata),
    .amm_byteenable   (amm_byteenable),
    .amm_readdata     (amm_readdata),
    .amm_readdatavalid(amm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .err_count        (err_count),
    .timeout          (timeout)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference beat: DATA_W/32 copies of one 32-bit word.
  function automatic logic [DATA_W-1:0] pat(input logic [31:0] w);
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DATA_W / 32; i++) p[i*32 +: 32] = w;
    return p;
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle. The DUT must be in IDLE.
  task automatic issue_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [BURST_W-1:0] l, input logic [31:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_seed  = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Reset values, and cmd_ready gating by reset and calibration.
  task automatic test_reset();
    rst = 1'b1;
    cal = 1'b1;
    tick();
    tick();
    checks++; if (amm_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_amm_write got %0b exp 0", amm_write); end
    checks++; if (amm_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_amm_read got %0b exp 0", amm_read); end
    checks++; if (amm_address !== '0) begin errors++; $display("[TB] FAIL rst_amm_address got %h exp 0", amm_address); end
    checks++; if (amm_burstcount !== '0) begin errors++; $display("[TB] FAIL rst_burstcount got %h exp 0", amm_burstcount); end
    checks++; if (amm_writedata !== '0) begin errors++; $display("[TB] FAIL rst_writedata got %h exp 0", amm_writedata[31:0]); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd_ready got %0b exp 0", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %0b exp 0", done); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_err_count got %0d exp 0", err_count); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL rst_timeout got %0b exp 0", timeout); end
    rst = 1'b0;
    cal = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL nocal_cmd_ready got %0b exp 0", cmd_ready); end
    cal = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL cal_cmd_ready got %0b exp 1", cmd_ready); end
  endtask

  // Write burst at full speed: four consecutive beats carrying 0x10..0x13.
  task automatic test_write_basic();
    amm_ready = 1'b1;
    issue_cmd(1'b1, 27'h100, 7'd4, 32'h10);
    for (int b = 0; b < 4; b++) begin
      checks++; if (amm_write !== 1'b1) begin errors++; $display("[TB] FAIL wr_strobe b%0d got %0b exp 1", b, amm_write); end
      checks++; if (amm_read !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_read b%0d got %0b exp 0", b, amm_read); end
      checks++; if (amm_address !== 27'h100 || amm_burstcount !== 7'd4) begin errors++; $display("[TB] FAIL wr_addr_bc b%0d got %h/%0d exp 100/4", b, amm_address, amm_burstcount); end
      checks++; if (amm_writedata !== pat(32'h10 + b)) begin errors++; $display("[TB] FAIL wr_data b%0d got %h exp %h", b, amm_writedata[31:0], 32'h10 + b); end
      checks++; if (amm_byteenable !== '1) begin errors++; $display("[TB] FAIL wr_byteenable b%0d got %h exp all ones", b, amm_byteenable); end
      checks++; if (busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy b%0d got busy=%0b done=%0b rdy=%0b exp 1/0/0", b, busy, done, cmd_ready); end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || amm_write !== 1'b0) begin errors++; $display("[TB] FAIL wr_done got done=%0b busy=%0b wr=%0b exp 1/0/0", done, busy, amm_write); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL wr_done_pulse got %0b exp 0", done); end
  endtask

  // Write burst with waitrequest held for 3 cycles at beat index 2.
  task automatic test_write_stall();
    int exp_b    = 0;
    int stall    = 0;
    int accepted = 0;
    int wr_cyc   = 0;
    bit seen     = 0;
    amm_ready = 1'b1;
    issue_cmd(1'b1, 27'h100, 7'd4, 32'h10);
    for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
      if (amm_write === 1'b1) begin
        wr_cyc++;
        checks++; if (amm_writedata !== pat(32'h10 + exp_b)) begin errors++; $display("[TB] FAIL stall_data b%0d got %h exp %h", exp_b, amm_writedata[31:0], 32'h10 + exp_b); end
        if (exp_b == 2 && stall < 3) begin
          amm_ready = 1'b0;
          stall++;
        end else begin
          amm_ready = 1'b1;
          accepted++;
          exp_b++;
        end
        tick();
      end else begin
        seen = (done === 1'b1);
        if (!seen) tick();
      end
    end
    amm_ready = 1'b1;
    checks++; if (!seen) begin errors++; $display("[TB] FAIL stall_done got no done exp done within 30 cycles"); end
    checks++; if (accepted != 4) begin errors++; $display("[TB] FAIL stall_beats got %0d exp 4", accepted); end
    checks++; if (wr_cyc != 7) begin errors++; $display("[TB] FAIL stall_write_cycles got %0d exp 7", wr_cyc); end
    tick();
  endtask

  // Read burst with waitrequest, stray readdatavalid in RD_REQ, and gaps.
  task automatic test_read_gaps();
    amm_ready = 1'b0;
    issue_cmd(1'b0, 27'h200, 7'd4, 32'h10);
    checks++; if (amm_read !== 1'b1 || amm_write !== 1'b0) begin errors++; $display("[TB] FAIL rd_req got rd=%0b wr=%0b exp 1/0", amm_read, amm_write); end
    checks++; if (amm_address !== 27'h200 || amm_burstcount !== 7'd4) begin errors++; $display("[TB] FAIL rd_addr_bc got %h/%0d exp 200/4", amm_address, amm_burstcount); end
    amm_readdatavalid = 1'b1;
    amm_readdata      = '1;
    tick();
    amm_readdatavalid = 1'b0;
    checks++; if (amm_read !== 1'b1) begin errors++; $display("[TB] FAIL rd_req_hold got %0b exp 1", amm_read); end
    amm_ready = 1'b1;
    tick();
    checks++; if (amm_read !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rd_data_state got rd=%0b busy=%0b exp 0/1", amm_read, busy); end
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 1) tick();
      amm_readdatavalid = 1'b1;
      amm_readdata      = pat(32'h10 + i);
      tick();
      amm_readdatavalid = 1'b0;
      if (i < 3) begin
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rd_mid b%0d got done=%0b busy=%0b exp 0/1", i, done, busy); end
      end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rd_done got done=%0b busy=%0b exp 1/0", done, busy); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL rd_err got %0d exp 0", err_count); end
    tick();
  endtask

  // Two-beat read with beat 1 corrupted, run twice: err_count 1, then 2.
  task automatic test_read_corrupt();
    amm_ready = 1'b1;
    for (int run = 0; run < 2; run++) begin
      issue_cmd(1'b0, 27'h300, 7'd2, 32'h55);
      tick();
      amm_readdatavalid = 1'b1;
      amm_readdata      = pat(32'h55);
      tick();
      amm_readdata      = pat(32'h56);
      amm_readdata[100] = ~amm_readdata[100];
      tick();
      amm_readdatavalid = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL corrupt_done run%0d got %0b exp 1", run, done); end
      checks++; if (err_count !== 16'(run + 1)) begin errors++; $display("[TB] FAIL corrupt_err run%0d got %0d exp %0d", run, err_count, run + 1); end
      tick();
    end
  endtask

  // Zero-length command: done the next cycle with no bus activity.
  task automatic test_zero_len();
    issue_cmd(1'b1, 27'h400, 7'd0, 32'h1);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zlen_done got done=%0b busy=%0b exp 1/0", done, busy); end
    checks++; if (amm_write !== 1'b0 || amm_read !== 1'b0) begin errors++; $display("[TB] FAIL zlen_bus got wr=%0b rd=%0b exp 0/0", amm_write, amm_read); end
    tick();
    checks++; if (done !== 1'b0 || amm_write !== 1'b0 || amm_read !== 1'b0) begin errors++; $display("[TB] FAIL zlen_after got done=%0b wr=%0b rd=%0b exp 0/0/0", done, amm_write, amm_read); end
  endtask

  // Reset during beat 2 of a write aborts it. Late read data is ignored.
  task automatic test_reset_midburst();
    amm_ready = 1'b1;
    issue_cmd(1'b1, 27'h500, 7'd4, 32'h20);
    tick();
    tick();
    checks++; if (amm_write !== 1'b1 || amm_writedata !== pat(32'h22)) begin errors++; $display("[TB] FAIL mid_beat2 got wr=%0b data=%h exp 1/22", amm_write, amm_writedata[31:0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (amm_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mid_abort got wr=%0b busy=%0b done=%0b exp 0/0/0", amm_write, busy, done); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_err_clear got %0d exp 0", err_count); end
    amm_readdatavalid = 1'b1;
    amm_readdata      = '1;
    tick();
    tick();
    amm_readdatavalid = 1'b0;
    checks++; if (err_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL late_rdv got err=%0d busy=%0b done=%0b exp 0/0/0", err_count, busy, done); end
  endtask

  // Read that never returns data: watchdog trip, or an indefinite wait.
  task automatic test_read_hang();
    int n = 0;
    amm_ready = 1'b1;
    issue_cmd(1'b0, 27'h600, 7'd1, 32'h0);
    tick();
`ifdef EMIF_AMM_MASTER_TIMEOUT_EN
    while (done !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    checks++; if (n != 1024) begin errors++; $display("[TB] FAIL wd_cycles got %0d exp 1024", n); end
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wd_flag got to=%0b busy=%0b exp 1/0", timeout, busy); end
    tick();
    checks++; if (timeout !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL wd_sticky got to=%0b done=%0b exp 1/0", timeout, done); end
`else
    for (int i = 0; i < 1100; i++) begin
      tick();
      n++;
    end
    checks++; if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL hang got busy=%0b done=%0b to=%0b after %0d exp 1/0/0", busy, done, timeout, n); end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL hang_reset got busy=%0b to=%0b exp 0/0", busy, timeout); end
  endtask

  // Scenario sequence.
  initial begin
    rst               = 1'b1;
    cal               = 1'b0;
    cmd_valid         = 1'b0;
    cmd_write         = 1'b0;
    cmd_addr          = '0;
    cmd_len           = '0;
    cmd_seed          = '0;
    amm_ready         = 1'b0;
    amm_readdata      = '0;
    amm_readdatavalid = 1'b0;
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read_gaps();
    test_read_corrupt();
    test_zero_len();
    test_reset_midburst();
    test_read_hang();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
